ram_dma_copy: RTL and testbench
===============================

# ram_dma_copy

Word-copy engine that drives port B of the 16-bit dual-port data RAM, moving a block of `length` words from `src_addr` to `dst_addr` while the processor keeps port A. It sits directly upstream of the RAM's port B: its `mem_*` outputs connect to `addr_b`, `data_b` and `we_b`, and its `mem_q` input connects to `q_b_out`. Copies use memmove semantics, so overlapping regions are copied correctly.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 10, RAM address width (1024 words)

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request a copy; sampled only in IDLE
- src_addr  input  ADDR_WIDTH  first source word
- dst_addr  input  ADDR_WIDTH  first destination word
- length  input  ADDR_WIDTH+1  word count, 0..1024
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse when the copy finishes
- mem_addr  output  ADDR_WIDTH  to RAM addr_b
- mem_data  output  DATA_WIDTH  to RAM data_b
- mem_we  output  1  to RAM we_b
- mem_q  input  DATA_WIDTH  from RAM q_b_out; registered read data, valid the cycle after the address is presented

## Operation
- The FSM has four states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - All outputs are low or zero.
  - On `start`, latch `src_addr`, `dst_addr` and `length`. Set `remaining = length`.
  - Choose direction: descending if `dst_addr > src_addr` (unsigned), ascending otherwise.
  - Ascending pointers: `rd_ptr = src`, `wr_ptr = dst`.
  - Descending pointers: `rd_ptr = src+length-1`, `wr_ptr = dst+length-1`.
  - Next state is READ if `length != 0`, else DONE.
- **READ**
  - `mem_addr = rd_ptr`, `mem_we = 0`.
  - Next state is WRITE.
- **WRITE**
  - `mem_addr = wr_ptr`, `mem_data = mem_q`, `mem_we = 1`.
  - At the edge, step both pointers by +1 (ascending) or -1 (descending) and decrement `remaining`.
  - Next state is DONE if `remaining == 1`, else READ.
- **DONE**
  - `done = 1`, `busy = 1`, `mem_we = 0`.
  - Next state is IDLE.
- Pointer arithmetic is modulo 2^ADDR_WIDTH: address 1023 + 1 wraps to 0, and 0 - 1 wraps to 1023. The direction test uses the unwrapped latched values only.
- `start` is ignored outside IDLE, and latched parameters cannot change mid-copy.
- `mem_addr`, `mem_data`, `mem_we`, `busy` and `done` are combinational decodes of registered state and pointers. They are glitch-free with respect to `start`.
- `mem_data` is zero outside WRITE.
- Reset during a copy:
  - State returns to IDLE asynchronously and all outputs drop at once.
  - A WRITE cycle interrupted before its edge performs no write.
  - No `done` pulse is issued, and words not yet written keep their old contents.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- For L ≥ 1:
  - Word k (k = 0..L-1) uses READ in cycle 2k+1 and WRITE in cycle 2k+2.
  - DONE is in cycle 2L+1.
  - IDLE is in cycle 2L+2, which is the earliest cycle a new `start` is accepted.
- For L = 0: DONE is in cycle 1 with no RAM access, and IDLE is in cycle 2.
- Throughput is 2 cycles per word. Total occupancy is 2L+1 busy cycles.
- Read latency is 1 cycle: `mem_q` in WRITE reflects the address driven in the preceding READ.
- Same-address collision with port A is not arbitrated here. Software must not write the destination range from port A while `busy` is high.
- Reset values:
  - state IDLE, `busy = 0`, `done = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_data = 0`
  - pointers = 0, `remaining = 0`

## Test plan
- **Basic ascending copy**
  - Stimulus: preload RAM[0x010..0x013] = 0xA000..0xA003; start with src=0x010, dst=0x100, len=4.
  - Response: `done` in cycle 9; RAM[0x100..0x103] = 0xA000..0xA003; `busy` high in cycles 1–9; source unchanged.
- **Overlap, destination above source**
  - Stimulus: RAM[0x20..0x24] = 1,2,3,4,5; start with src=0x20, dst=0x22, len=5.
  - Response: descending order is used; RAM[0x22..0x26] = 1,2,3,4,5.
- **Overlap, destination below source**
  - Stimulus: same preload; start with src=0x22, dst=0x20, len=3.
  - Response: RAM[0x20..0x22] = 3,4,5.
- **Wrap-around**
  - Stimulus: src=0x3FE, dst=0x010, len=4.
  - Response: reads addresses 0x3FE, 0x3FF, 0x000, 0x001; writes 0x010..0x013.
- **Zero length and start while busy**
  - Stimulus: start with len=0.
  - Response: `done` in cycle 1, `mem_we` never asserts, IDLE in cycle 2.
  - Stimulus: a second start pulsed while busy during a len=3 copy.
  - Response: ignored; exactly one `done`.
- **Reset mid-copy**
  - Stimulus: len=8 copy; assert reset during cycle 6 (WRITE of word 2), before its edge.
  - Response: `mem_we` drops immediately; only words 0–1 are written; no `done`; all outputs zero; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/ram_dma_copy.sv
// Word-copy engine on RAM port B; memmove-safe (descending order when dst > src).
// Latency: 2 cycles per word (READ then WRITE) plus one DONE cycle; L=0 goes straight to DONE.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module ram_dma_copy #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE = 1;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  descending;
    logic [ADDR_WIDTH-1:0] span_m1;

    // Low bits of length suffice: length 1024 gives span_m1 = 1023, i.e. -1 mod 1024.
    assign span_m1 = length[ADDR_WIDTH-1:0] - PTR_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy      = 1'b1;
                mem_addr  = rd_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_addr  = wr_ptr;
                mem_data  = mem_q;
                mem_we    = 1'b1;
                state_nxt = (remaining == REM_ONE) ? DONE : READ;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            remaining  <= '0;
            descending <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                remaining  <= length;
                descending <= (dst_addr > src_addr);
                if (dst_addr > src_addr) begin
                    rd_ptr <= src_addr + span_m1;
                    wr_ptr <= dst_addr + span_m1;
                end else begin
                    rd_ptr <= src_addr;
                    wr_ptr <= dst_addr;
                end
            end else if (state == WRITE) begin
                remaining <= remaining - REM_ONE;
                if (descending) begin
                    rd_ptr <= rd_ptr - PTR_ONE;
                    wr_ptr <= wr_ptr - PTR_ONE;
                end else begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Bench for ram_dma_copy: port-B RAM behavioural model, directed test-plan cases and random copies
// checked cycle by cycle against a word-order copy model.
module tb_ram_dma_copy;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] mdl [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_dma_copy #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    // Port B of the data RAM: registered read, write on we; pl_* is a bench-only preload path.
    always @(posedge clk) begin
        mem_q <= ram[mem_addr];
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_we)
            ram[mem_addr] <= mem_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = AW'(a);
        pl_data = d;
        mdl[a]  = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic compare_ram(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== mdl[i]) mism++;
        chk(tag, mism, 0);
    endtask

    // One copy: every busy cycle is compared against the expected schedule, and the model is
    // updated word by word in the order the copy direction dictates.
    task automatic run_copy(input int src, input int dst, input int len,
                            input int poke_c, input int abort_c);
        int            desc, k, rd, wr, last;
        logic [28:0]   exp;
        desc = (dst > src) ? 1 : 0;
        last = (len == 0) ? 2 : 2 * len + 2;
        @(negedge clk);
        start    = 1'b1;
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        length   = (AW+1)'(len);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length   = (AW+1)'($urandom);
        for (int c = 1; c <= last; c++) begin
            k  = (c - 1) / 2;
            rd = desc ? (src + len - 1 - k) % DEPTH : (src + k) % DEPTH;
            wr = desc ? (dst + len - 1 - k) % DEPTH : (dst + k) % DEPTH;
            if (c == last)
                exp = '0;
            else if (c == last - 1)
                exp = {3'b110, 26'd0};
            else if (c % 2 == 1)
                exp = {3'b100, AW'(rd), 16'd0};
            else
                exp = {3'b101, AW'(wr), mdl[rd]};
            chk($sformatf("cyc%0d s%0h d%0h l%0d", c, src, dst, len),
                {busy, done, mem_we, mem_addr, mem_data}, exp);
            if (c == abort_c) begin
                reset = 1'b1;
                #1;
                chk("reset_midcopy_outputs", {busy, done, mem_we, mem_addr, mem_data}, 0);
                @(posedge clk);
                @(negedge clk);
                chk("reset_held_outputs", {busy, done, mem_we, mem_addr, mem_data}, 0);
                reset = 1'b0;
                return;
            end
            if (len != 0 && c % 2 == 0 && c < last - 1)
                mdl[wr] = mdl[rd];
            start = (c == poke_c);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int s, d, l;
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        pl_en    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        #1;
        chk("reset_outputs", {busy, done, mem_we, mem_addr, mem_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("idle_after_reset", {busy, done, mem_we, mem_addr, mem_data}, 0);

        for (int i = 0; i < DEPTH; i++)
            preload(i, DW'($urandom));

        // Basic ascending copy
        for (int i = 0; i < 4; i++) preload(16'h010 + i, 16'hA000 + DW'(i));
        run_copy(16'h010, 16'h100, 4, 0, 0);
        compare_ram("ram_basic");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_dst%0d", i), ram[16'h100 + i], 16'hA000 + i);
            chk($sformatf("basic_src%0d", i), ram[16'h010 + i], 16'hA000 + i);
        end

        // Overlap, destination above source
        for (int i = 0; i < 5; i++) preload(16'h20 + i, DW'(i + 1));
        run_copy(16'h20, 16'h22, 5, 0, 0);
        compare_ram("ram_overlap_up");
        for (int i = 0; i < 5; i++)
            chk($sformatf("overlap_up%0d", i), ram[16'h22 + i], i + 1);

        // Overlap, destination below source
        for (int i = 0; i < 5; i++) preload(16'h20 + i, DW'(i + 1));
        run_copy(16'h22, 16'h20, 3, 0, 0);
        compare_ram("ram_overlap_down");
        for (int i = 0; i < 3; i++)
            chk($sformatf("overlap_down%0d", i), ram[16'h20 + i], i + 3);

        // Wrap-around of the read pointer
        run_copy(16'h3FE, 16'h010, 4, 0, 0);
        compare_ram("ram_wrap");

        // Zero length, then a start pulsed while busy
        run_copy(5, 9, 0, 0, 0);
        compare_ram("ram_zero_len");
        run_copy(16'h40, 16'h80, 3, 2, 0);
        compare_ram("ram_start_while_busy");

        // Reset during the WRITE of word 2, then a fresh copy
        run_copy(16'h200, 16'h300, 8, 0, 6);
        compare_ram("ram_after_reset");
        run_copy(16'h200, 16'h300, 8, 0, 0);
        compare_ram("ram_after_restart");

        // Full-memory length, descending with wrap
        run_copy(5, 700, 1024, 0, 0);
        compare_ram("ram_full_len");

        for (int t = 0; t < 25; t++) begin
            s = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1)
                d = (s + $urandom_range(0, 8) + DEPTH - 4) % DEPTH;
            else
                d = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 40);
            run_copy(s, d, l, (t % 3 == 0) ? 3 : 0, 0);
            compare_ram($sformatf("ram_rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
